// File: rtl/srff_arb_pkg.sv
// Shared types for the set/clear flip-flop access arbiter: opcodes, FSM states
// and the expected-readback helper.
package srff_arb_pkg;

    localparam int TW_DEF = 32;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_APPLY = 3'd2,
        ST_CHECK = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Value the cell should hold after the operation; read has no expectation.
    function automatic logic op_expect(op_e op, logic din);
        case (op)
            OP_LOAD: return din;
            OP_SET:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/srff_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request at or after ptr,
// wrapping, as a one-hot grant plus its index.
module rr_pick
    import srff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/srff_access_arbiter.sv
// Round-robin access controller for one shared set/clear flip-flop cell, with
// taint labels carried alongside every drive and result.
module srff_access_arbiter
    import srff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TW    = TW_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [2*N_REQ-1:0]  OP,
    input  logic [TW*N_REQ-1:0] OP_T,
    input  logic [N_REQ-1:0]    DIN,
    input  logic [TW*N_REQ-1:0] DIN_T,
    output logic [N_REQ-1:0]    GNT,
    output logic                DONE,
    output logic                RESULT,
    output logic [TW-1:0]       RESULT_T,
    output logic                ERR,
    output logic [TW-1:0]       ERR_T,
    output logic                FF_D,
    output logic                FF_SET,
    output logic                FF_CLR,
    output logic [TW-1:0]       FF_D_T,
    output logic [TW-1:0]       FF_SET_T,
    output logic [TW-1:0]       FF_CLR_T,
    input  logic                FF_Q,
    input  logic [TW-1:0]       FF_Q_T
);

    localparam int IW = $clog2(N_REQ);

    state_e            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     idx_q;
    logic [N_REQ-1:0]  pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    int                sel;

    op_e               op_q;
    logic              din_q;
    logic [TW-1:0]     op_t_q;
    logic [TW-1:0]     din_t_q;

    function automatic logic [TW-1:0] err_taint(op_e op, logic [TW-1:0] q_t,
                                                logic [TW-1:0] o_t, logic [TW-1:0] d_t);
        case (op)
            OP_LOAD:        return q_t | o_t | d_t;
            OP_SET, OP_CLR: return q_t | o_t;
            default:        return '0;
        endcase
    endfunction

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req (REQ),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign sel = int'(pick_idx);

    // Operand latches: captured once at grant, so later REQ/OP changes are ignored.
    always_ff @(posedge CLK) begin
        if (state == ST_IDLE && pick_any) begin
            op_q    <= op_e'(OP[2*sel +: 2]);
            op_t_q  <= OP_T[TW*sel +: TW];
            din_q   <= DIN[sel];
            din_t_q <= DIN_T[TW*sel +: TW];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            idx_q    <= '0;
            GNT      <= '0;
            DONE     <= 1'b0;
            RESULT   <= 1'b0;
            RESULT_T <= '0;
            ERR      <= 1'b0;
            ERR_T    <= '0;
            FF_D     <= 1'b0;
            FF_SET   <= 1'b0;
            FF_CLR   <= 1'b0;
            FF_D_T   <= '0;
            FF_SET_T <= '0;
            FF_CLR_T <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        GNT   <= pick_gnt;
                        idx_q <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                // GRANT -> APPLY: drive the cell for exactly one cycle
                ST_GRANT: begin
                    FF_D     <= (op_q == OP_LOAD) & din_q;
                    FF_D_T   <= din_t_q;
                    FF_SET   <= (op_q == OP_SET);
                    FF_SET_T <= (op_q == OP_SET) ? op_t_q : '0;
                    FF_CLR   <= (op_q == OP_CLR);
                    FF_CLR_T <= (op_q == OP_CLR) ? op_t_q : '0;
                    state    <= ST_APPLY;
                end
                // APPLY -> CHECK: release set/clear, keep D steady for readback
                ST_APPLY: begin
                    FF_SET   <= 1'b0;
                    FF_SET_T <= '0;
                    FF_CLR   <= 1'b0;
                    FF_CLR_T <= '0;
                    state    <= ST_CHECK;
                end
                // CHECK -> RESP: sample the cell and compare
                ST_CHECK: begin
                    FF_D     <= 1'b0;
                    FF_D_T   <= '0;
                    DONE     <= 1'b1;
                    RESULT   <= FF_Q;
                    RESULT_T <= FF_Q_T;
                    ERR      <= (op_q != OP_READ) && (FF_Q != op_expect(op_q, din_q));
                    ERR_T    <= err_taint(op_q, FF_Q_T, op_t_q, din_t_q);
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    DONE     <= 1'b0;
                    RESULT   <= 1'b0;
                    RESULT_T <= '0;
                    ERR      <= 1'b0;
                    ERR_T    <= '0;
                    GNT      <= '0;
                    ptr      <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_srff_access_arbiter.sv
// Scoreboard bench for srff_access_arbiter with a behavioural set/clear cell
// that can be overridden to force readback values.
module tb_srff_access_arbiter;
    import srff_arb_pkg::*;

    localparam int N  = 4;
    localparam int TW = 32;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [N-1:0]    REQ = '0;
    logic [2*N-1:0]  OP = '0;
    logic [TW*N-1:0] OP_T = '0;
    logic [N-1:0]    DIN = '0;
    logic [TW*N-1:0] DIN_T = '0;
    logic [N-1:0]    GNT;
    logic            DONE, RESULT, ERR, FF_D, FF_SET, FF_CLR, FF_Q;
    logic [TW-1:0]   RESULT_T, ERR_T, FF_D_T, FF_SET_T, FF_CLR_T, FF_Q_T;

    logic            cell_q = 1'b0;
    logic [TW-1:0]   cell_qt = '0;
    logic            force_en = 1'b0;
    logic            force_q = 1'b0;
    logic [TW-1:0]   force_qt = '0;

    typedef struct {
        int            exp_cyc;
        logic [N-1:0]  gnt;
        logic          res;
        logic [TW-1:0] res_t;
        logic          err;
        logic [TW-1:0] err_t;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    srff_access_arbiter #(.N_REQ(N), .TW(TW)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OP(OP), .OP_T(OP_T),
        .DIN(DIN), .DIN_T(DIN_T), .GNT(GNT), .DONE(DONE),
        .RESULT(RESULT), .RESULT_T(RESULT_T), .ERR(ERR), .ERR_T(ERR_T),
        .FF_D(FF_D), .FF_SET(FF_SET), .FF_CLR(FF_CLR),
        .FF_D_T(FF_D_T), .FF_SET_T(FF_SET_T), .FF_CLR_T(FF_CLR_T),
        .FF_Q(FF_Q), .FF_Q_T(FF_Q_T)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Cell model: set/clear dominate, otherwise D is captured every edge.
    always @(posedge CLK) begin
        if (FF_SET) begin
            cell_q  <= 1'b1;
            cell_qt <= FF_SET_T;
        end else if (FF_CLR) begin
            cell_q  <= 1'b0;
            cell_qt <= FF_CLR_T;
        end else begin
            cell_q  <= FF_D;
            cell_qt <= FF_D_T;
        end
    end

    assign FF_Q   = force_en ? force_q  : cell_q;
    assign FF_Q_T = force_en ? force_qt : cell_qt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every DONE pulse pops and compares one expectation.
    always @(negedge CLK) begin
        if (RST_N && DONE) begin
            if (sbq.size() == 0) begin
                chk("done_unexpected", 32'(DONE), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", 32'(cyc),      32'(e.exp_cyc));
                chk("gnt_at_done", 32'(GNT),     32'(e.gnt));
                chk("result",     32'(RESULT),   32'(e.res));
                chk("result_t",   RESULT_T,      e.res_t);
                chk("err",        32'(ERR),      32'(e.err));
                chk("err_t",      ERR_T,         e.err_t);
            end
        end
    end

    task automatic do_txn(input int idx, input logic [N-1:0] extra, input logic [1:0] op,
                          input logic din, input logic [TW-1:0] op_t, input logic [TW-1:0] din_t,
                          input logic res, input logic [TW-1:0] res_t,
                          input logic err, input logic [TW-1:0] err_t, input bit drop);
        exp_t e;
        logic [N-1:0] g;
        g = '0;
        g[idx] = 1'b1;
        @(negedge CLK);
        REQ = extra | g;
        OP[2*idx +: 2]     = op;
        DIN[idx]           = din;
        OP_T[TW*idx +: TW] = op_t;
        DIN_T[TW*idx +: TW] = din_t;
        e.exp_cyc = cyc + 4;
        e.gnt = g; e.res = res; e.res_t = res_t; e.err = err; e.err_t = err_t;
        sbq.push_back(e);
        @(negedge CLK);
        chk("gnt_c1", 32'(GNT), 32'(g));
        chk("drv_c1", 32'({FF_D, FF_SET, FF_CLR}), 32'd0);
        @(negedge CLK);
        chk("ff_set_c2",   32'(FF_SET), 32'(op == 2'b01));
        chk("ff_clr_c2",   32'(FF_CLR), 32'(op == 2'b10));
        chk("ff_d_c2",     32'(FF_D),   32'(op == 2'b00 && din));
        chk("ff_set_t_c2", FF_SET_T,    (op == 2'b01) ? op_t : 32'd0);
        chk("ff_clr_t_c2", FF_CLR_T,    (op == 2'b10) ? op_t : 32'd0);
        chk("ff_d_t_c2",   FF_D_T,      din_t);
        if (drop) REQ = '0;
        @(negedge CLK);
        chk("drv_sc_c3", 32'({FF_SET, FF_CLR}), 32'd0);
        chk("ff_d_c3",   32'(FF_D), 32'(op == 2'b00 && din));
        chk("ff_d_t_c3", FF_D_T, din_t);
        @(negedge CLK);
        chk("done_c4", 32'(DONE), 32'd1);
        REQ = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (2) @(negedge CLK);
        chk("reset_gnt",   32'(GNT), 32'd0);
        chk("reset_ctrl",  32'({DONE, RESULT, ERR, FF_D, FF_SET, FF_CLR}), 32'd0);
        chk("reset_taint", RESULT_T | ERR_T | FF_D_T | FF_SET_T | FF_CLR_T, 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // load 1 on requester 0: Q_T = DIN_T, ERR_T = 0x1|0x10|0x1
        do_txn(0, 4'b0000, 2'b00, 1'b1, 32'h10, 32'h1, 1'b1, 32'h1, 1'b0, 32'h11, 1'b0);
        // set on requester 2, then clear on requester 3 (pointer ends at 0)
        do_txn(2, 4'b0000, 2'b01, 1'b0, 32'h4, 32'h0, 1'b1, 32'h4, 1'b0, 32'h4, 1'b0);
        do_txn(3, 4'b0000, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'h40, 1'b0, 32'h40, 1'b0);

        // fairness: all four hold REQ with set ops for eight transactions
        @(negedge CLK);
        OP  = 8'b01_01_01_01;
        DIN = '0;
        DIN_T = '0;
        for (int i = 0; i < N; i++) OP_T[TW*i +: TW] = 32'h100 << i;
        REQ = 4'hF;
        c = cyc;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.exp_cyc = c + 4 + 5 * k;
            e.gnt     = 4'b0001 << (k % 4);
            e.res     = 1'b1;
            e.res_t   = 32'h100 << (k % 4);
            e.err     = 1'b0;
            e.err_t   = 32'h100 << (k % 4);
            sbq.push_back(e);
        end
        repeat (39) @(negedge CLK);
        REQ = '0;

        // mismatch: cell forced to 0 on a set from requester 1
        force_en = 1'b1; force_q = 1'b0; force_qt = 32'h8;
        do_txn(1, 4'b0000, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, 32'h8, 1'b1, 32'h28, 1'b0);
        force_en = 1'b0;

        // reset during APPLY of a set from requester 2
        @(negedge CLK);
        OP[5:4] = 2'b01;
        OP_T[TW*2 +: TW] = 32'h4;
        REQ = 4'b0100;
        @(negedge CLK);
        chk("rst_gnt_before", 32'(GNT), 32'h4);
        @(negedge CLK);
        chk("rst_set_before", 32'(FF_SET), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_ff_set",   32'(FF_SET), 32'd0);
        chk("rst_ff_set_t", FF_SET_T,    32'd0);
        chk("rst_gnt",      32'(GNT),    32'd0);
        chk("rst_done",     32'(DONE),   32'd0);
        REQ = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);

        // after reset the pointer is 0: requester 0 wins over 2
        do_txn(0, 4'b0100, 2'b00, 1'b0, 32'h1, 32'h2, 1'b0, 32'h2, 1'b0, 32'h3, 1'b0);

        // read with forced readback, REQ dropped mid-transaction
        force_en = 1'b1; force_q = 1'b1; force_qt = 32'hF0;
        do_txn(1, 4'b0000, 2'b11, 1'b1, 32'h3, 32'h7, 1'b1, 32'hF0, 1'b0, 32'h0, 1'b1);
        force_en = 1'b0;

        repeat (6) @(negedge CLK);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srff_access_arbiter.md
# srff_access_arbiter

Round-robin access controller that shares one set/clear D flip-flop cell (the taint-instrumented dffsr datapath) between `N_REQ` requesters. Each transaction is one operation (load D, set, clear, read), driven to the cell for one cycle and then read back and checked. The block returns the result and a mismatch flag, and propagates 32-bit taint labels alongside every data and control value for information-flow tracking.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8
- `TW`, 32: taint label width

Ports:
- `CLK`  in  1  system clock; the controlled cell is clocked on the same edge
- `RST_N`  in  1  asynchronous, active-low reset
- `REQ`  in  N_REQ  per-requester request level
- `OP`  in  2*N_REQ  per-requester opcode: 00 load D, 01 set, 10 clear, 11 read
- `OP_T`  in  TW*N_REQ  taint of each opcode
- `DIN`  in  N_REQ  per-requester data bit for load
- `DIN_T`  in  TW*N_REQ  taint of each data bit
- `GNT`  out  N_REQ  one-hot grant, held for the whole transaction
- `DONE`  out  1  one-cycle completion pulse to the granted requester
- `RESULT`, `RESULT_T`  out  1, TW  cell value read back, and its taint
- `ERR`, `ERR_T`  out  1, TW  readback mismatch, and its taint
- `FF_D`, `FF_SET`, `FF_CLR`  out  1 each  registered drives to the cell; SET and CLR are active-high
- `FF_D_T`, `FF_SET_T`, `FF_CLR_T`  out  TW each  taints of the drives
- `FF_Q`, `FF_Q_T`  in  1, TW  cell output and its taint

## Operation
- **Reset values:** all outputs 0, FSM in IDLE, round-robin pointer at 0.
- **FSM states:** IDLE → GRANT → APPLY → CHECK → RESP → IDLE.
- **IDLE:** when any `REQ` is high, pick the first requester at or after the pointer (wrapping), latch its `OP`, `OP_T`, `DIN` and `DIN_T`, then go to GRANT. If no request, stay in IDLE.
- **GRANT:** drive `GNT` one-hot. All `FF_*` outputs stay 0.
- **APPLY:** drive the cell for exactly one cycle:
  - load: `FF_D` = latched DIN
  - set: `FF_SET` = 1
  - clear: `FF_CLR` = 1
  - read: nothing asserted
- **Expected value:** DIN for load, 1 for set, 0 for clear; no expectation for read.
- **CHECK:** all drives return to 0 (the D value is held). Sample `FF_Q` and `FF_Q_T` at the end of this cycle.
- **RESP:** `DONE` = 1. `RESULT` = sampled Q. `ERR` = (sampled Q ≠ expected), forced to 0 for read. The pointer moves to granted index + 1, mod `N_REQ`. `GNT` drops when leaving RESP.
- **Taint propagation:**
  - `FF_D_T` = latched DIN_T in APPLY and CHECK, else 0
  - `FF_SET_T` and `FF_CLR_T` = latched OP_T while that drive is asserted, else 0
  - `RESULT_T` = sampled Q_T
  - `ERR_T` = Q_T | OP_T | DIN_T for load; Q_T | OP_T for set and clear; 0 for read
- **Boundary conditions:**
  - Dropping `REQ` after the grant does not abort; the transaction completes.
  - New or changed requests during a transaction are ignored until IDLE.
  - A requester holding `REQ` high is re-granted only after the others have had their turn.
  - `RST_N` asserted mid-transaction immediately zeroes every output, including an in-flight `FF_SET` or `FF_CLR`. Partial effects on the cell are not undone.

## Timing
- REQ sampled at edge 0 → GNT high in cycle 1 → drive in cycle 2 → readback in cycle 3 → DONE in cycle 4.
- Fixed latency: 4 cycles from the request edge to DONE. An idle cycle is mandatory between transactions, so the period is 5 cycles.
- All outputs are registered; no combinational path from input to output.
- Back-to-back requests: the next grant begins the cycle after returning to IDLE.

## Structure
- Shared package `srff_arb_pkg`:
  - opcode enum (`OP_LOAD`, `OP_SET`, `OP_CLR`, `OP_READ`)
  - FSM state enum
  - `TW` default constant
- One sub-module, `rr_pick`: a combinational round-robin selector (request vector + pointer → one-hot grant + index).
- The FSM, operand latches and taint muxing live in the top module.

## Test plan
- **Load data:** reset, then REQ=0001, OP0=00, DIN0=1, DIN0_T=0x1. Expect FF_D=1 in cycle 2, DONE in cycle 4, RESULT=1, ERR=0, ERR_T=0x1|Q_T.
- **Set and clear:** requester 2 sets with OP2_T=0x4 → FF_SET high for exactly one cycle with FF_SET_T=0x4, RESULT=1. A following clear → RESULT=0.
- **Fairness:** REQ=1111 held for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3 and DONE every 5 cycles.
- **Mismatch:** the bench cell model forces Q=0 on a set. Expect ERR=1 and ERR_T = Q_T|OP_T.
- **Reset mid-operation:** pull RST_N low during APPLY of a set. Expect FF_SET, GNT and DONE at 0 immediately, FSM in IDLE, next grant to requester 0.
- **Read and dropped request:** read op with FF_Q=1 and Q_T=0xF0. Expect RESULT=1, RESULT_T=0xF0, ERR=0, ERR_T=0. Drop REQ in cycle 2; DONE still fires in cycle 4.
